// File: rtl/ysyx_23060203_xbar_pkg.sv
// Shared definitions for the ysyx_23060203 AXI crossbars.
//   - FSM state and slave-select enums
//   - AXI response codes
//   - default address map (CLINT, main memory)
//   - xbar_decode(): address -> slave select, shared by read and write crossbars
package ysyx_23060203_xbar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ERR
  } xbar_state_e;

  // SEL_NONE encodes as zero so a cleared select register means "no slave".
  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_MEM,
    SEL_CLINT
  } xbar_sel_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] DEF_CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] DEF_CLINT_SIZE = 32'h0001_0000;
  localparam logic [31:0] DEF_MEM_BASE   = 32'h8000_0000;
  localparam logic [31:0] DEF_MEM_SIZE   = 32'h0800_0000;

  // Offset compare rather than addr < base + size, so a region ending at the
  // top of the address space cannot wrap.
  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] size);
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && (off < size);
  endfunction

  function automatic xbar_sel_e xbar_decode(input logic [31:0] addr,
                                            input logic [31:0] clint_base,
                                            input logic [31:0] clint_size,
                                            input logic [31:0] mem_base,
                                            input logic [31:0] mem_size);
    if (addr_hit(addr, clint_base, clint_size)) return SEL_CLINT;
    if (addr_hit(addr, mem_base, mem_size))     return SEL_MEM;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 bundle used between the core's read master, the crossbar and the slaves.
// Read channels are full width (32-bit addr/data, 4-bit id, 8-bit len); the
// write channels carry handshakes only, since nothing in this slice writes.
//   modport in  : crossbar side facing a master
//   modport out : crossbar side facing a slave
interface axi_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  logic        awvalid;
  logic        awready;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport in (
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready,
    input  awvalid, wvalid, bready,
    output awready, wready, bvalid
  );

  modport out (
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready,
    output awvalid, wvalid, bready,
    input  awready, wready, bvalid
  );
endinterface

// File: rtl/ysyx_23060203_axi_err_r.sv
// Internal DECERR read responder: answers arlen+1 beats of zero data with
// RESP_DECERR for a request that decoded to no slave.
//   clock, reset    : clock, synchronous active-high reset
//   start_i         : pulse when an unmapped AR is accepted
//   arid_i, arlen_i : latched request id/length (stable while active)
//   rready_i        : master R-channel ready
//   rvalid_o .. rid_o : R-channel outputs, valid while active
//   done_o          : pulses on the rlast handshake
module ysyx_23060203_axi_err_r
  import ysyx_23060203_xbar_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start_i,
  input  logic [3:0]  arid_i,
  input  logic [7:0]  arlen_i,
  input  logic        rready_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o,
  output logic [3:0]  rid_o,
  output logic        done_o
);

  logic       active_q;
  logic [7:0] cnt_q;
  logic       last;

  assign last = (cnt_q == arlen_i);

  always_ff @(posedge clock) begin
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
    end else if (active_q && rready_i) begin
      if (last) begin
        active_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign rvalid_o = active_q;
  assign rdata_o  = '0;
  assign rresp_o  = active_q ? RESP_DECERR : RESP_OKAY;
  assign rlast_o  = active_q && last;
  assign rid_o    = arid_i;
  assign done_o   = active_q && rready_i && last;

endmodule

// File: rtl/ysyx_23060203_rxbar.sv
// Read-only AXI crossbar: one read master to main memory, the CLINT and an
// internal DECERR responder. One transaction outstanding at a time; the
// request is latched on acceptance and replayed to the selected slave with
// araddr held until the final R handshake (the CLINT reads from live araddr).
//   clock, reset : clock, synchronous active-high reset
//   up           : from the read master (ar/r used, write handshakes idle)
//   mem          : to the memory read port
//   clint        : to the CLINT read port
module ysyx_23060203_rxbar
  import ysyx_23060203_xbar_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = DEF_CLINT_BASE,
  parameter logic [31:0] CLINT_SIZE = DEF_CLINT_SIZE,
  parameter logic [31:0] MEM_BASE   = DEF_MEM_BASE,
  parameter logic [31:0] MEM_SIZE   = DEF_MEM_SIZE
) (
  input logic clock,
  input logic reset,
  axi_if.in   up,
  axi_if.out  mem,
  axi_if.out  clint
);

  xbar_state_e state_q;
  xbar_sel_e   sel_q;
  logic [31:0] araddr_q;
  logic [3:0]  arid_q;
  logic [7:0]  arlen_q;
  logic [2:0]  arsize_q;
  logic [1:0]  arburst_q;

  xbar_sel_e   dec_sel;
  logic        slv_arready;
  logic        slv_rvalid;
  logic [31:0] slv_rdata;
  logic [1:0]  slv_rresp;
  logic        slv_rlast;

  logic        err_start;
  logic        err_rvalid;
  logic [31:0] err_rdata;
  logic [1:0]  err_rresp;
  logic        err_rlast;
  logic [3:0]  err_rid;
  logic        err_done;

  assign dec_sel = xbar_decode(up.araddr, CLINT_BASE, CLINT_SIZE, MEM_BASE, MEM_SIZE);
  assign err_start = !reset && (state_q == ST_IDLE) && up.arvalid && (dec_sel == SEL_NONE);

  ysyx_23060203_axi_err_r u_err (
    .clock    (clock),
    .reset    (reset),
    .start_i  (err_start),
    .arid_i   (arid_q),
    .arlen_i  (arlen_q),
    .rready_i (up.rready),
    .rvalid_o (err_rvalid),
    .rdata_o  (err_rdata),
    .rresp_o  (err_rresp),
    .rlast_o  (err_rlast),
    .rid_o    (err_rid),
    .done_o   (err_done)
  );

  always_comb begin
    slv_arready = 1'b0;
    slv_rvalid  = 1'b0;
    slv_rdata   = '0;
    slv_rresp   = RESP_OKAY;
    slv_rlast   = 1'b0;
    case (sel_q)
      SEL_MEM: begin
        slv_arready = mem.arready;
        slv_rvalid  = mem.rvalid;
        slv_rdata   = mem.rdata;
        slv_rresp   = mem.rresp;
        slv_rlast   = mem.rlast;
      end
      SEL_CLINT: begin
        slv_arready = clint.arready;
        slv_rvalid  = clint.rvalid;
        slv_rdata   = clint.rdata;
        slv_rresp   = clint.rresp;
        slv_rlast   = clint.rlast;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= SEL_NONE;
      araddr_q  <= '0;
      arid_q    <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (up.arvalid) begin
            araddr_q  <= up.araddr;
            arid_q    <= up.arid;
            arlen_q   <= up.arlen;
            arsize_q  <= up.arsize;
            arburst_q <= up.arburst;
            sel_q     <= dec_sel;
            state_q   <= (dec_sel == SEL_NONE) ? ST_ERR : ST_ADDR;
          end
        end
        ST_ADDR: if (slv_arready) state_q <= ST_DATA;
        ST_DATA: if (slv_rvalid && up.rready && slv_rlast) state_q <= ST_IDLE;
        ST_ERR:  if (err_done) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem.araddr    = araddr_q;
  assign mem.arid      = arid_q;
  assign mem.arlen     = arlen_q;
  assign mem.arsize    = arsize_q;
  assign mem.arburst   = arburst_q;
  assign clint.araddr  = araddr_q;
  assign clint.arid    = arid_q;
  assign clint.arlen   = arlen_q;
  assign clint.arsize  = arsize_q;
  assign clint.arburst = arburst_q;

  assign mem.awvalid   = 1'b0;
  assign mem.wvalid    = 1'b0;
  assign mem.bready    = 1'b0;
  assign clint.awvalid = 1'b0;
  assign clint.wvalid  = 1'b0;
  assign clint.bready  = 1'b0;
  assign up.awready    = 1'b0;
  assign up.wready     = 1'b0;
  assign up.bvalid     = 1'b0;

  // Handshake outputs are forced inactive while reset is held, whatever the
  // state register still shows, so nothing leaks during the reset cycle.
  always_comb begin
    up.arready  = 1'b0;
    up.rvalid   = 1'b0;
    up.rdata    = '0;
    up.rresp    = RESP_OKAY;
    up.rlast    = 1'b0;
    up.rid      = '0;
    mem.arvalid   = 1'b0;
    mem.rready    = 1'b0;
    clint.arvalid = 1'b0;
    clint.rready  = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: up.arready = 1'b1;
        ST_ADDR: begin
          mem.arvalid   = (sel_q == SEL_MEM);
          clint.arvalid = (sel_q == SEL_CLINT);
        end
        ST_DATA: begin
          up.rvalid    = slv_rvalid;
          up.rdata     = slv_rdata;
          up.rresp     = slv_rresp;
          up.rlast     = slv_rlast;
          up.rid       = arid_q;
          mem.rready   = (sel_q == SEL_MEM) && up.rready;
          clint.rready = (sel_q == SEL_CLINT) && up.rready;
        end
        ST_ERR: begin
          up.rvalid = err_rvalid;
          up.rdata  = err_rdata;
          up.rresp  = err_rresp;
          up.rlast  = err_rlast;
          up.rid    = err_rid;
        end
        default: ;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{mem.rid, clint.rid, mem.awready, mem.wready, mem.bvalid,
                       clint.awready, clint.wready, clint.bvalid,
                       up.awvalid, up.wvalid, up.bready};

endmodule

// File: tb/tb_ysyx_23060203_rxbar.sv
module tb_ysyx_23060203_rxbar;
  import ysyx_23060203_xbar_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  axi_if up ();
  axi_if mem ();
  axi_if clint ();

  ysyx_23060203_rxbar #(
    .CLINT_BASE(32'h0200_0000),
    .CLINT_SIZE(32'h0001_0000),
    .MEM_BASE  (32'h8000_0000),
    .MEM_SIZE  (32'h0800_0000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .up   (up),
    .mem  (mem),
    .clint(clint)
  );

  // CLINT model: always ready, one beat, rdata from live araddr.
  localparam logic [31:0] MTIME_HI = 32'hCAFE_0001;
  logic [63:0] mtime_q;
  logic        clint_rv_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      mtime_q    <= {MTIME_HI, 32'h0};
      clint_rv_q <= 1'b0;
    end else begin
      mtime_q <= mtime_q + 64'd1;
      if (clint.arvalid && clint.arready) clint_rv_q <= 1'b1;
      else if (clint.rvalid && clint.rready) clint_rv_q <= 1'b0;
    end
  end
  assign clint.arready = 1'b1;
  assign clint.rvalid  = clint_rv_q;
  assign clint.rdata   = clint.araddr[2] ? mtime_q[63:32] : mtime_q[31:0];
  assign clint.rresp   = 2'b00;
  assign clint.rlast   = 1'b1;
  assign clint.rid     = 4'hF;
  assign clint.awready = 1'b0;
  assign clint.wready  = 1'b0;
  assign clint.bvalid  = 1'b0;

  // Memory model: arready one cycle after arvalid, data = addr + 4*beat.
  logic        mem_seen_q, mem_act_q;
  logic [31:0] mem_addr_q;
  logic [7:0]  mem_len_q, mem_beat_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_seen_q <= 1'b0;
      mem_act_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_len_q  <= '0;
      mem_beat_q <= '0;
    end else begin
      mem_seen_q <= mem.arvalid && !mem.arready;
      if (mem.arvalid && mem.arready) begin
        mem_act_q  <= 1'b1;
        mem_addr_q <= mem.araddr;
        mem_len_q  <= mem.arlen;
        mem_beat_q <= '0;
      end else if (mem_act_q && mem.rready) begin
        if (mem_beat_q == mem_len_q) mem_act_q <= 1'b0;
        else mem_beat_q <= mem_beat_q + 8'd1;
      end
    end
  end
  assign mem.arready = mem.arvalid && mem_seen_q;
  assign mem.rvalid  = mem_act_q;
  assign mem.rdata   = mem_addr_q + {22'd0, mem_beat_q, 2'b00};
  assign mem.rresp   = 2'b00;
  assign mem.rlast   = mem_act_q && (mem_beat_q == mem_len_q);
  assign mem.rid     = 4'hE;
  assign mem.awready = 1'b0;
  assign mem.wready  = 1'b0;
  assign mem.bvalid  = 1'b0;

  int unsigned mem_ar_cnt = 0;
  int unsigned clint_ar_cnt = 0;
  always @(posedge clock) begin
    if (mem.arvalid && mem.arready) mem_ar_cnt <= mem_ar_cnt + 1;
    if (clint.arvalid && clint.arready) clint_ar_cnt <= clint_ar_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    @(negedge clock);
    up.arvalid = 1'b1;
    up.araddr  = addr;
    up.arid    = id;
    up.arlen   = len;
    up.arsize  = 3'd2;
    up.arburst = 2'b01;
    #1 chk("ar_accept", {63'd0, up.arready}, 64'd1);
    @(posedge clock);
  endtask

  // Runs one transaction after its AR handshake; first_exp is the cycle index
  // (0 = AR cycle + 1) at which the first beat must be accepted.
  task automatic collect(input string tag, input xbar_sel_e sel, input logic [31:0] addr,
                         input logic [3:0] id, input int unsigned len,
                         input logic [31:0] d0, input logic [31:0] dstep,
                         input logic [1:0] resp, input bit toggle,
                         input int unsigned first_exp);
    int unsigned beat = 0;
    int unsigned cyc = 0;
    int unsigned first = 99;
    bit rr = 1'b1;
    logic [7:0] len8;
    len8 = 8'(len);
    while (beat <= len && cyc < 40) begin
      @(negedge clock);
      up.arvalid = 1'b0;
      up.rready  = toggle ? rr : 1'b1;
      rr = !rr;
      #1;
      chk({tag, " arready busy"}, {63'd0, up.arready}, 64'd0);
      if (sel != SEL_MEM)   chk({tag, " mem idle"}, {62'd0, mem.arvalid, mem.rready}, 64'd0);
      if (sel != SEL_CLINT) chk({tag, " clint idle"}, {62'd0, clint.arvalid, clint.rready}, 64'd0);
      if (sel == SEL_MEM) begin
        chk({tag, " mem araddr"}, {32'd0, mem.araddr}, {32'd0, addr});
        if (mem.arvalid) chk({tag, " mem ar fields"}, {51'd0, mem.arlen, mem.arsize, mem.arburst},
                             {51'd0, len8, 3'd2, 2'b01});
        if (up.rvalid) chk({tag, " mem rready"}, {63'd0, mem.rready}, {63'd0, up.rready});
      end
      if (sel == SEL_CLINT) begin
        chk({tag, " clint araddr"}, {32'd0, clint.araddr}, {32'd0, addr});
        if (clint.arvalid) chk({tag, " clint ar fields"}, {51'd0, clint.arlen, clint.arsize, clint.arburst},
                               {51'd0, len8, 3'd2, 2'b01});
        if (up.rvalid) chk({tag, " clint rready"}, {63'd0, clint.rready}, {63'd0, up.rready});
      end
      if (up.rvalid && up.rready) begin
        if (beat == 0) first = cyc;
        chk({tag, " rdata"}, {32'd0, up.rdata}, {32'd0, d0 + dstep * beat});
        chk({tag, " rresp"}, {62'd0, up.rresp}, {62'd0, resp});
        chk({tag, " rlast"}, {63'd0, up.rlast}, {63'd0, beat == len});
        chk({tag, " rid"}, {60'd0, up.rid}, {60'd0, id});
        beat++;
      end
      @(posedge clock);
      cyc++;
    end
    chk({tag, " beats"}, 64'(beat), 64'(len + 1));
    chk({tag, " first beat cycle"}, 64'(first), 64'(first_exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    up.arvalid = 1'b0; up.araddr = '0; up.arid = '0; up.arlen = '0;
    up.arsize = '0; up.arburst = '0; up.rready = 1'b1;
    up.awvalid = 1'b0; up.wvalid = 1'b0; up.bready = 1'b0;

    repeat (2) @(negedge clock);
    #1;
    chk("reset arready", {63'd0, up.arready}, 64'd0);
    chk("reset rvalid", {63'd0, up.rvalid}, 64'd0);
    chk("reset slave ar/r", {60'd0, mem.arvalid, mem.rready, clint.arvalid, clint.rready}, 64'd0);
    chk("reset slave araddr", {32'd0, mem.araddr}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post-reset arready", {63'd0, up.arready}, 64'd1);

    // CLINT read of mtime[63:32]
    issue(32'h0200_0004, 4'd3, 8'd0);
    collect("clint", SEL_CLINT, 32'h0200_0004, 4'd3, 0, MTIME_HI, 32'd0, 2'b00, 1'b0, 1);

    // 4-beat memory burst, rready toggling
    issue(32'h8000_0000, 4'd2, 8'd3);
    collect("mem burst", SEL_MEM, 32'h8000_0000, 4'd2, 3, 32'h8000_0000, 32'd4, 2'b00, 1'b1, 2);

    // Unmapped read
    issue(32'h1000_0000, 4'd5, 8'd1);
    collect("decerr", SEL_NONE, 32'h1000_0000, 4'd5, 1, 32'd0, 32'd0, 2'b11, 1'b0, 0);
    chk("decerr no slave ar", 64'(mem_ar_cnt + clint_ar_cnt), 64'd2);

    // Address-map boundaries
    issue(32'h0200_FFFC, 4'd7, 8'd0);
    collect("clint top", SEL_CLINT, 32'h0200_FFFC, 4'd7, 0, MTIME_HI, 32'd0, 2'b00, 1'b0, 1);
    issue(32'h0201_0000, 4'd8, 8'd0);
    collect("clint end", SEL_NONE, 32'h0201_0000, 4'd8, 0, 32'd0, 32'd0, 2'b11, 1'b0, 0);
    issue(32'h87FF_FFFC, 4'd9, 8'd0);
    collect("mem top", SEL_MEM, 32'h87FF_FFFC, 4'd9, 0, 32'h87FF_FFFC, 32'd4, 2'b00, 1'b0, 2);
    issue(32'h8800_0000, 4'd10, 8'd0);
    collect("mem end", SEL_NONE, 32'h8800_0000, 4'd10, 0, 32'd0, 32'd0, 2'b11, 1'b0, 0);
    issue(32'hFFFF_FFFC, 4'd11, 8'd0);
    collect("addr max", SEL_NONE, 32'hFFFF_FFFC, 4'd11, 0, 32'd0, 32'd0, 2'b11, 1'b0, 0);

    // Back-to-back with arvalid held high
    issue(32'h0200_0004, 4'd1, 8'd0);
    @(negedge clock);
    up.araddr = 32'h1000_0000; up.arid = 4'd6; up.arlen = 8'd0; up.rready = 1'b1;
    #1 chk("b2b addr arready", {63'd0, up.arready}, 64'd0);
    @(negedge clock);
    #1;
    chk("b2b first beat", {58'd0, up.rvalid, up.rlast, up.rid}, {58'd0, 1'b1, 1'b1, 4'd1});
    chk("b2b data arready", {63'd0, up.arready}, 64'd0);
    @(negedge clock);
    #1 chk("b2b second accept", {63'd0, up.arready}, 64'd1);
    @(negedge clock);
    up.arvalid = 1'b0;
    #1 chk("b2b second beat", {56'd0, up.rvalid, up.rlast, up.rresp, up.rid},
           {56'd0, 1'b1, 1'b1, 2'b11, 4'd6});

    // Reset during the second beat of a 4-beat memory burst
    issue(32'h8000_0010, 4'd4, 8'd3);
    @(negedge clock);
    up.arvalid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #1 chk("rst burst beat1", {31'd0, up.rvalid, up.rdata}, {31'd0, 1'b1, 32'h8000_0010});
    @(negedge clock);
    reset = 1'b1;
    #1 chk("rst cycle outputs", {61'd0, up.rvalid, mem.rready, up.arready}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("after rst idle", {60'd0, up.arready, up.rvalid, mem.rready, mem.rvalid}, {60'd0, 4'b1000});
    issue(32'h0200_0004, 4'd9, 8'd0);
    collect("clint after rst", SEL_CLINT, 32'h0200_0004, 4'd9, 0, MTIME_HI, 32'd0, 2'b00, 1'b0, 1);

    chk("write tied off", {55'd0, mem.awvalid, mem.wvalid, mem.bready, clint.awvalid,
        clint.wvalid, clint.bready, up.awready, up.wready, up.bvalid}, 64'd0);
    chk("slave ar totals", {32'(mem_ar_cnt), 32'(clint_ar_cnt)}, {32'd3, 32'd4});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
